// File: rtl/instruction_fetch_issue.sv
// IF stage: PC register, word-addressed instruction memory, and a bubble
// inserter that follows every issued instruction with NOP_PAD zero words.
module instruction_fetch_issue #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned NOP_PAD   = 5,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        ImemWe,
    input  logic [31:0] ImemAddr,
    input  logic [31:0] ImemWData,
    output logic [31:0] Instruction,
    output logic [31:0] PCAddResult,
    output logic [31:0] PC,
    output logic        IssueValid
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {
        ST_ISSUE,
        ST_PAD
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  pad_cnt, pad_cnt_nx;
    logic [31:0] pc_nx, instr_nx, par_nx;
    logic        valid_nx;

    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] fetch_word;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        write_ok;
    logic        unused_addr_bits;

    // Addresses past the end of memory read as zero rather than aliasing.
    assign fetch_word = (PC[31:AW+2] == '0) ? mem[PC[AW+1:2]] : '0;

    assign redirect        = Jump | PCSrc;
    assign redirect_target = Jump ? (JumpTarget & ~32'd3) : (BranchTarget & ~32'd3);

    assign write_ok         = (ImemAddr[31:AW+2] == '0);
    assign unused_addr_bits = ^ImemAddr[1:0];

    always_comb begin
        state_nx   = state;
        pad_cnt_nx = pad_cnt;
        pc_nx      = PC;
        instr_nx   = Instruction;
        par_nx     = PCAddResult;
        valid_nx   = IssueValid;

        // A redirect moves the PC even while stalled; everything else holds.
        if (redirect) begin
            pc_nx = redirect_target;
        end

        if (!Stall) begin
            unique case (state)
                ST_ISSUE: begin
                    if (redirect) begin
                        instr_nx = '0;
                        valid_nx = 1'b0;
                    end else begin
                        instr_nx = fetch_word;
                        par_nx   = PC + 32'd4;
                        pc_nx    = PC + 32'd4;
                        valid_nx = 1'b1;
                        if (NOP_PAD != 0) begin
                            state_nx   = ST_PAD;
                            pad_cnt_nx = 4'(NOP_PAD);
                        end
                    end
                end
                ST_PAD: begin
                    instr_nx   = '0;
                    valid_nx   = 1'b0;
                    pad_cnt_nx = pad_cnt - 4'd1;
                    if (pad_cnt == 4'd1) begin
                        state_nx = ST_ISSUE;
                    end
                end
                default: begin
                    state_nx = ST_ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_ISSUE;
            pad_cnt     <= '0;
            PC          <= RESET_PC;
            Instruction <= '0;
            PCAddResult <= '0;
            IssueValid  <= 1'b0;
        end else begin
            state       <= state_nx;
            pad_cnt     <= pad_cnt_nx;
            PC          <= pc_nx;
            Instruction <= instr_nx;
            PCAddResult <= par_nx;
            IssueValid  <= valid_nx;
        end
    end

    // Not reset: program load may happen while the core is held in reset.
    always_ff @(posedge Clk) begin
        if (ImemWe && write_ok) begin
            mem[ImemAddr[AW+1:2]] <= ImemWData;
        end
    end

endmodule
